// File: rtl/seq_mul_if.sv
// seq_mul_if: bundles every non-clock signal of the bit-serial multiplier driver.
//   master modport: the driver (seq_mul_driver) side.
//   slave modport:  the environment side, meaning the requester plus the multiplier.
// Signals:
//   start/ready          request handshake; a_in/b_in are sampled on an accepted start
//   mul_out              multiplicand, held for the whole frame
//   seq_reset            one-cycle clear pulse to the multiplier
//   bit_out/bit_valid    serial multiplier, LSB first
//   prod_in              product returned by the multiplier
//   prod_out/done/err    captured product, completion strobe, mismatch flag
interface seq_mul_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic                   ready;
    logic [WIDTH-1:0]       a_in;
    logic [WIDTH-1:0]       b_in;
    logic [WIDTH-1:0]       mul_out;
    logic                   seq_reset;
    logic                   bit_out;
    logic                   bit_valid;
    logic [2*WIDTH-1:0]     prod_in;
    logic [2*WIDTH-1:0]     prod_out;
    logic                   done;
    logic                   err;

    modport master (
        input  start, a_in, b_in, prod_in,
        output ready, mul_out, seq_reset, bit_out, bit_valid, prod_out, done, err
    );

    modport slave (
        output start, a_in, b_in, prod_in,
        input  ready, mul_out, seq_reset, bit_out, bit_valid, prod_out, done, err
    );
endinterface

// File: rtl/seq_mul_driver.sv
// seq_mul_driver: bit-serial operand driver for the sequential multiplier.
// Operation:
//   - Accepts an a/b pair on start while ready is high.
//   - Pulses seq_reset for one cycle.
//   - Shifts b out LSB-first for WIDTH cycles while holding a on mul_out.
//   - Waits DRAIN idle cycles.
//   - Captures prod_in into prod_out, with a one-cycle done strobe.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    seq_mul_if.master (handshake, serial stream, product return)
// Parameters:
//   WIDTH  operand width and serial frame length
//   DRAIN  idle cycles between the last bit and the capture (0 allowed)
// Optional build macro: PROD_CHECK_EN.
//   Adds a reference multiplier. err is then raised together with done when
//   prod_in differs from mul_out * b. Without the macro, err is tied low.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | ready=1, waiting for start
// ST_CLR   | seq_reset pulse to multiplier
// ST_SHIFT | bit_out = current LSB of multiplier, bit_valid=1
// ST_DRAIN | waiting for the multiplier to settle
// ST_DONE  | prod_out valid, done=1
module seq_mul_driver #(
    parameter int WIDTH = 8,
    parameter int DRAIN = 1
) (
    input  logic         clk,
    input  logic         reset,
    seq_mul_if.master    bus
);
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int DW    = (DRAIN > 0) ? $clog2(DRAIN + 1) : 1;
    localparam int DLOAD = (DRAIN > 0) ? DRAIN - 1 : 0;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLR   = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [CW-1:0]      cnt;
    logic [DW-1:0]      dcnt;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   mul_q;
    logic [2*WIDTH-1:0] prod_q;
    logic               capture;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = ST_CLR;
            ST_CLR:   state_nxt = ST_SHIFT;
            ST_SHIFT: if (cnt == CW'(WIDTH - 1))
                          state_nxt = (DRAIN > 0) ? ST_DRAIN : ST_DONE;
            ST_DRAIN: if (dcnt == '0) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // The product is sampled on the edge that enters DONE, whichever state we come from.
    assign capture = (state_nxt == ST_DONE) && (state != ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            dcnt   <= '0;
            shreg  <= '0;
            mul_q  <= '0;
            prod_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        mul_q <= bus.a_in;
                        shreg <= bus.b_in;
                        cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    shreg <= shreg >> 1;
                    cnt   <= cnt + 1'b1;
                    // The drain down-counter is preloaded so that its terminal count
                    // is reached after DRAIN cycles.
                    dcnt  <= DW'(DLOAD);
                end
                ST_DRAIN: begin
                    if (dcnt != '0) dcnt <= dcnt - 1'b1;
                end
                default: ;
            endcase
            if (capture) prod_q <= bus.prod_in;
        end
    end

`ifdef PROD_CHECK_EN
    // Keep an unshifted copy of b, because shreg is consumed during SHIFT.
    logic [WIDTH-1:0]   b_lat;
    logic [2*WIDTH-1:0] ref_prod;
    logic               err_q;

    assign ref_prod = (2*WIDTH)'(mul_q) * (2*WIDTH)'(b_lat);

    always_ff @(posedge clk) begin
        if (reset) begin
            b_lat <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == ST_IDLE && bus.start) b_lat <= bus.b_in;
            // err_q is written every cycle, so it can only be high during DONE.
            err_q <= capture && (bus.prod_in != ref_prod);
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.ready     = (state == ST_IDLE);
    assign bus.seq_reset = (state == ST_CLR);
    assign bus.bit_valid = (state == ST_SHIFT);
    assign bus.bit_out   = (state == ST_SHIFT) & shreg[0];
    assign bus.done      = (state == ST_DONE);
    assign bus.mul_out   = mul_q;
    assign bus.prod_out  = prod_q;
endmodule

// File: doc/seq_mul_driver.md
# seq_mul_driver

Bit-serial operand driver for the sequential multiplier. Accepts a multiplicand/multiplier pair via a start/ready handshake and clears the multiplier through a one-cycle reset pulse. It then holds the multiplicand steady, shifts the multiplier out LSB-first one bit per clock, waits a programmable drain time, and captures the 2·WIDTH-bit product with a one-cycle done strobe. It is the sending end of the serial-bit interface that the sequential multiplier consumes.

## Interface
- WIDTH, 8, operand width; serial frame length in bits
- DRAIN, 1, idle cycles between last serial bit and product capture (0 allowed)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when ready=1
- ready  out  1  high in IDLE only
- a_in  in  WIDTH  multiplicand, sampled on accepted start
- b_in  in  WIDTH  multiplier, sampled on accepted start
- mul_out  out  WIDTH  latched multiplicand to multiplier, stable for whole frame
- seq_reset  out  1  one-cycle clear pulse to multiplier before first bit
- bit_out  out  1  serial multiplier bit, LSB first
- bit_valid  out  1  high during the WIDTH shift cycles
- prod_in  in  2·WIDTH  product returned by multiplier
- prod_out  out  2·WIDTH  captured product, held until next capture or reset
- done  out  1  one-cycle strobe, prod_out valid
- err  out  1  product mismatch flag (see Configuration)

## Operation
- States: IDLE, CLR, SHIFT, DRAIN, DONE.
- IDLE: ready=1. start=1 → latch a_in into mul_out and b_in into shift register, cnt←0, go CLR. start=0 → stay.
- CLR: seq_reset=1 for exactly one cycle, go SHIFT.
- SHIFT: bit_out=shreg[0], bit_valid=1; shift right each cycle, cnt++. After the WIDTH-th bit → DRAIN if DRAIN>0, else DONE.
- DRAIN: bit_valid=0, bit_out=0; count DRAIN cycles → DONE.
- DONE: prod_out holds prod_in sampled on the edge entering DONE; done=1; go IDLE.
- start outside IDLE ignored; no queuing. a_in/b_in changes after acceptance have no effect.
- mul_out holds the last operand after the frame ends; cleared only by reset.
- Counter width: clog2(WIDTH+1) for shift, clog2(DRAIN+1) for drain (min 1 bit).

## Timing
- start accepted at edge 0 → CLR cycle 1, SHIFT cycles 2..WIDTH+1, DRAIN cycles WIDTH+2..WIDTH+1+DRAIN, DONE cycle WIDTH+2+DRAIN.
- WIDTH=8, DRAIN=1: done high in cycle 11; ready back high in cycle 12. Back-to-back start in cycle 12 → next done in cycle 23.
- Reset values: ready=1 (after release), mul_out=0, seq_reset=0, bit_out=0, bit_valid=0, prod_out=0, done=0, err=0, state IDLE.
- reset high in any state, including mid-SHIFT: all outputs at reset values on the following edge; frame abandoned; no done.
- reset and start same cycle: reset wins, start dropped.
- b_in=0: full WIDTH-cycle frame still emitted (all zeros). No early termination.

## Configuration
- PROD_CHECK_EN defined: internal reference product mul_out × latched b computed; err=1 together with done when prod_in ≠ reference at capture, else err=0; err cleared on the cycle after DONE.
- Not defined: no reference multiplier synthesized; err tied 0.

## Test plan
- Reset for 2 cycles, release → ready=1, all other outputs 0, state IDLE.
- a=37, b=16, start once → seq_reset pulse cycle 1; bit_out 0,0,0,0,1,0,0,0 in cycles 2..9 with bit_valid=1; multiplier model returns 592; done cycle 11, prod_out=16'h0250.
- a=255, b=255 back-to-back with a=3, b=0 started in cycle 12 → first done prod_out=65025; second frame emits eight 0 bits, prod_out=0 at cycle 23.
- start held high during SHIFT with different operands → ignored; mul_out and bit stream unchanged; exactly one done.
- reset asserted in cycle 5 of a frame → next cycle bit_valid=0, ready=1, prod_out=0, no done.
- PROD_CHECK_EN with model forced to return 591 for 37×16 → err=1 in done cycle; correct model → err=0.
